// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package kbd_pkg;

    localparam logic [7:0] KBD_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] KBD_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } kbd_event_t;

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// CPU-side I/O bus of the keyboard controller: pop/clear in, head event and flags out.
// Latency: none (wiring only).
// Backpressure: the CPU pops one event per cycle of rd; the queue never stalls the CPU.
interface kbd_event_ctrl_if;

    logic       rd;
    logic       clr;
    logic [7:0] data;
    logic       brk;
    logic       ext;
    logic       valid;
    logic       interrupt;
    logic       overflow;
    logic       err;

    modport master (
        output rd, clr,
        input  data, brk, ext, valid, interrupt, overflow, err
    );

    modport slave (
        input  rd, clr,
        output data, brk, ext, valid, interrupt, overflow, err
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: pin synchroniser, 11-bit frame FSM and inter-edge watchdog (macro KBD_PARITY_CHECK_EN enables parity checking).
// Latency: frame_done / frame_err pulse one cycle after the stop-bit falling edge is detected.
// Backpressure: none; the keyboard cannot be stalled, every completed frame is reported.
module ps2_rx_frame
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic [7:0] rx_byte,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic clk_s1, clk_s2, clk_s3;
    logic dat_s1, dat_s2;
    logic fall;
    logic bit_in;

    frame_state_t state, state_nxt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] idle_cnt;
    logic          timeout;
    logic          frame_ok;
    logic          done_nxt, err_nxt;

    // Two-flop synchronisers; the extra clock flop keeps the previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= kb_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= kb_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall    = clk_s3 & ~clk_s2;
    assign bit_in  = dat_s2;
    assign timeout = (idle_cnt == TW'(TIMEOUT_CYC));
    assign rx_byte = shreg;

`ifdef KBD_PARITY_CHECK_EN
    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign frame_ok = bit_in & (^{shreg, par_bit});
`else
    assign frame_ok = bit_in;
`endif

    // Frame state register and registered completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
        end
    end

    // Next-state: advance only on a kb_clk falling edge; the watchdog pulls a stalled frame back to idle.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (fall) begin
            case (state)
                ST_IDLE:   if (!bit_in) state_nxt = ST_DATA;
                ST_DATA:   if (bitcnt == 3'd7) state_nxt = ST_PARITY;
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP: begin
                    state_nxt = ST_IDLE;
                    done_nxt  = frame_ok;
                    err_nxt   = ~frame_ok;
                end
                default:   state_nxt = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && timeout) begin
            state_nxt = ST_IDLE;
        end
    end

    // Bit capture: LSB arrives first, so shift right and insert at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt  <= 3'd0;
            shreg   <= 8'd0;
            par_bit <= 1'b0;
        end else if (fall) begin
            case (state)
                ST_IDLE:   bitcnt <= 3'd0;
                ST_DATA: begin
                    shreg  <= {bit_in, shreg[7:1]};
                    bitcnt <= bitcnt + 3'd1;
                end
                ST_PARITY: par_bit <= bit_in;
                default:   ;
            endcase
        end
    end

    // Watchdog: counts cycles since the last falling edge while a frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state == ST_IDLE || fall || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// PS/2 keyboard controller: folds E0/F0 prefixes into key events, queues them, raises an interrupt (macro KBD_PARITY_CHECK_EN enables parity checking).
// Latency: io_ctrl.valid rises two cycles after the stop-bit falling edge is detected.
// Backpressure: none toward the keyboard; events arriving at a full queue are dropped and flagged in overflow.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int INT_LEVEL   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               io_keyboard_kb_clk,
    input  logic               io_keyboard_kb_data,
    kbd_event_ctrl_if.slave    io_ctrl
);

    localparam int           AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       frame_done;
    logic       frame_err;

    logic       ext_pend, brk_pend;
    logic       push_req, push_ok, pop, full, valid, ovf_set;
    logic       irq_q, ovf_q, err_q;

    kbd_event_t          mem [FIFO_DEPTH];
    kbd_event_t          head;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;

    ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .kb_clk     (io_keyboard_kb_clk),
        .kb_data    (io_keyboard_kb_data),
        .rx_byte    (rx_byte),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    assign push_req = frame_done && (rx_byte != KBD_PREFIX_EXT) && (rx_byte != KBD_PREFIX_BRK);
    assign valid    = (count != '0);
    assign full     = (count == DEPTH_C);
    assign pop      = io_ctrl.rd && valid;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign head     = mem[rd_ptr];

    // Prefix flags: remembered until a real scancode consumes them, even if that event is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_done) begin
            if (rx_byte == KBD_PREFIX_EXT) begin
                ext_pend <= 1'b1;
            end else if (rx_byte == KBD_PREFIX_BRK) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // Event storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{brk: brk_pend, ext: ext_pend, code: rx_byte};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Interrupt pulse and sticky flags; a new set event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            irq_q <= push_ok;
            ovf_q <= ovf_set   | (ovf_q & ~io_ctrl.clr);
            err_q <= frame_err | (err_q & ~io_ctrl.clr);
        end
    end

    assign io_ctrl.data      = valid ? head.code : 8'd0;
    assign io_ctrl.brk       = valid & head.brk;
    assign io_ctrl.ext       = valid & head.ext;
    assign io_ctrl.valid     = valid;
    assign io_ctrl.interrupt = (INT_LEVEL != 0) ? valid : irq_q;
    assign io_ctrl.overflow  = ovf_q;
    assign io_ctrl.err       = err_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Bench for kbd_event_ctrl: PS/2 frames driven on the pins, events checked by a scoreboard monitor.
// Latency: checks valid two cycles after the stop-bit edge is detected.
// Backpressure: the monitor pops whenever draining is enabled.
module tb_kbd_event_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
`ifdef KBD_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic kb_clk  = 1'b1;
    logic kb_data = 1'b1;

    kbd_event_ctrl_if io();

    kbd_event_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO),
        .INT_LEVEL   (1)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .io_keyboard_kb_clk  (kb_clk),
        .io_keyboard_kb_data (kb_data),
        .io_ctrl             (io)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [9:0] exp_q[$];
    bit         m_ext = 0, m_brk = 0, m_ovf = 0, m_err = 0;
    bit         drain_en = 0;
    int         half = 5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what the keyboard stream means, independent of how the RTL frames it.
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            m_err = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_brk, m_ext, b});
            else                      m_ovf = 1;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        kb_data = b;
        repeat (half) @(negedge clk);
        kb_clk = 1'b0;
        repeat (half) @(negedge clk);
        kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop, input bit lat);
        logic p;
        p = ~(^b) ^ par_bad;
        model_frame(b, stop && !(PAR_EN && par_bad));
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        if (lat) begin
            @(negedge clk);
            kb_data = stop;
            repeat (half) @(negedge clk);
            kb_clk = 1'b0;
            repeat (3) @(posedge clk);
            #1 chk("latency_t1_valid", io.valid, 0);
            @(posedge clk);
            #1 chk("latency_t2_valid", io.valid, 1);
            chk("latency_t2_irq", io.interrupt, 1);
            repeat (half) @(negedge clk);
            kb_clk = 1'b1;
        end else begin
            ps2_bit(stop);
        end
        @(negedge clk);
        kb_data = 1'b1;
        repeat (2 * half) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || io.valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, (exp_q.size() == 0 && !io.valid)}, 1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        io.clr = 1'b1;
        @(negedge clk);
        io.clr = 1'b0;
        m_ovf = 0;
        m_err = 0;
    endtask

    // Monitor: compares each presented head event against the scoreboard, then pops it.
    initial begin
        io.rd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (drain_en && io.valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %0h expected none", {io.brk, io.ext, io.data});
                end else begin
                    chk("event", {22'd0, io.brk, io.ext, io.data}, {22'd0, exp_q.pop_front()});
                    chk("irq_level", io.interrupt, 1);
                end
                io.rd = 1'b1;
                @(posedge clk);
                #1 io.rd = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        io.clr = 1'b0;

        // Reset state
        #1;
        chk("rst_valid", io.valid, 0);
        chk("rst_data", io.data, 0);
        chk("rst_brk", io.brk, 0);
        chk("rst_ext", io.ext, 0);
        chk("rst_irq", io.interrupt, 0);
        chk("rst_ovf", io.overflow, 0);
        chk("rst_err", io.err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single make code with latency check, then pop
        send_frame(8'h1C, 0, 1, 1);
        drain_en = 1;
        wait_drain("t1_drain");
        chk("t1_valid_after_pop", io.valid, 0);
        chk("t1_irq_after_pop", io.interrupt, 0);

        // Break prefix alone must not produce an entry
        drain_en = 0;
        send_frame(8'hF0, 0, 1, 0);
        chk("t2_no_entry_after_f0", io.valid, 0);
        send_frame(8'h1C, 0, 1, 0);
        drain_en = 1;
        wait_drain("t2_drain");

        // Extended break, then flags must be clear
        send_frame(8'hE0, 0, 1, 0);
        send_frame(8'hF0, 0, 1, 0);
        send_frame(8'h75, 0, 1, 0);
        send_frame(8'h1C, 0, 1, 0);
        wait_drain("t3_drain");

        // Overflow: one more event than the queue holds
        drain_en = 0;
        for (int v = 1; v <= DEPTH + 1; v++) send_frame(8'(v), 0, 1, 0);
        chk("t4_ovf_set", io.overflow, m_ovf);
        chk("t4_valid_full", io.valid, 1);
        drain_en = 1;
        wait_drain("t4_drain");
        pulse_clr();
        chk("t4_ovf_clr", io.overflow, m_ovf);

        // Watchdog abort of a partial frame
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TMO + 1) @(negedge clk);
        send_frame(8'h1C, 0, 1, 0);
        wait_drain("t5_drain");
        chk("t5_err", io.err, 0);

        // Bad parity
        send_frame(8'h1C, 1, 1, 0);
        wait_drain("t6_par_drain");
        chk("t6_par_err", io.err, m_err);
        pulse_clr();
        chk("t6_err_clr", io.err, m_err);

        // Bad stop bit
        send_frame(8'h1C, 0, 0, 0);
        wait_drain("t6_stop_drain");
        chk("t6_stop_err", io.err, m_err);
        pulse_clr();

        // Randomized stream with prefixes and occasional framing faults
        for (int n = 0; n < 40; n++) begin
            half = $urandom_range(3, 8);
            case ($urandom_range(0, 3))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0), 0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_drain("rand_drain");
        chk("rand_err", io.err, m_err);
        chk("rand_ovf", io.overflow, m_ovf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
